// File: rtl/store_pkg.sv
// Shared encodings for the store narrowing path: access sizes and FSM states.
// Optional overflow reporting is enabled in store_narrow_unit with STORE_OVF_CHECK_EN.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Rejects sub-word accesses that straddle their natural boundary and the illegal size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian lane insert: replaces the byte/halfword lane selected by addr_lo
// in old_word with the low bits of new_data; all other bits are preserved.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = new_data[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) merged[31:16] = new_data[15:0];
        else            merged[15:0]  = new_data[15:0];
      end
      SZ_WORD: merged = new_data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// MIPS store path: SB/SH via read-modify-write, SW as a direct write, misaligned rejected.
// Define STORE_OVF_CHECK_EN to report narrowing overflow on the ovf output.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        misaligned,
  output logic        ovf,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata
);

  if (RD_LAT != 1) begin : g_bad_rd_lat
    $error("store_narrow_unit supports only RD_LAT == 1");
  end

  state_t      state, state_n;
  logic        accept;
  logic [31:0] lat_addr;
  logic [15:0] lat_data;
  logic [1:0]  lat_size;
  logic [31:0] merged_word;
  logic [31:0] word_addr;
  logic [31:0] wdata_n;

  assign req_ready = rst_n && (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Only the low halfword is needed after acceptance; words bypass the merge.
  store_lane_merge u_merge (
    .old_word (mem_rdata),
    .new_data ({16'h0000, lat_data}),
    .size     (lat_size),
    .addr_lo  (lat_addr[1:0]),
    .merged   (merged_word)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_misaligned(req_size, req_addr[1:0])) state_n = S_ERR;
          else if (req_size == SZ_WORD)               state_n = S_WRITE;
          else                                        state_n = S_READ;
        end
      end
      S_READ:  state_n = S_MERGE;
      S_MERGE: state_n = S_WRITE;
      S_WRITE: state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Leaving IDLE the request ports are still live; afterwards the latched copy is used.
  assign word_addr = (state == S_IDLE) ? {req_addr[31:2], 2'b00} : {lat_addr[31:2], 2'b00};
  assign wdata_n   = (state == S_IDLE) ? req_data : merged_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      done       <= (state == S_WRITE) || (state == S_ERR);
      misaligned <= (state == S_ERR);
      mem_rd_en  <= (state_n == S_READ);
      mem_wr_en  <= (state_n == S_WRITE);
      if ((state_n == S_READ) || (state_n == S_WRITE)) mem_addr <= word_addr;
      if (state_n == S_WRITE) mem_wdata <= wdata_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr <= req_addr;
      lat_data <= req_data[15:0];
      lat_size <= req_size;
    end
  end

`ifdef STORE_OVF_CHECK_EN
  logic lat_ovf;

  // True when the register value is not the sign-extension of the stored field.
  function automatic logic narrow_ovf(input logic [1:0] size, input logic signed [31:0] d);
    case (size)
      SZ_BYTE: return d[31:8]  != {24{d[7]}};
      SZ_HALF: return d[31:16] != {16{d[15]}};
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (accept) lat_ovf <= narrow_ovf(req_size, req_data);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= (state == S_WRITE) && lat_ovf;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store path for the MIPS datapath.
- Takes a 32-bit register value and writes it into word-organised data memory as a byte (SB), halfword (SH) or word (SW).
- It is the narrowing direction, the inverse of the load-side 16->32 sign extension.
- Sub-word stores use a multi-cycle read-modify-write FSM with a valid/ready request handshake and a completion pulse.

Parameters:
- RD_LAT, 1, memory read latency in cycles; only the value 1 is supported. It is documentation and elaboration-checked, not a generic.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  32  byte address.
- req_data  in  32  register value; the low bits are stored.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- done  out  1  one-cycle pulse when the request completes.
- misaligned  out  1  valid with done; the request was rejected with no memory access.
- ovf  out  1  valid with done; narrowing lost information (see Optional Feature).
- mem_addr  out  32  word-aligned memory address ({addr[31:2],2'b00}).
- mem_rd_en  out  1  memory read strobe; mem_rdata is valid the next cycle.
- mem_rdata  in  32  memory read data.
- mem_wr_en  out  1  memory write strobe, single cycle.
- mem_wdata  out  32  full word to write.

Behaviour:
- States: IDLE, READ, MERGE, WRITE, ERR.
- Reset:
  - rst_n low on a clock edge forces state IDLE.
  - Reset value 0 for done, misaligned, ovf, mem_rd_en, mem_wr_en, mem_addr and mem_wdata.
  - req_ready is 0 while rst_n is low, and 1 in IDLE otherwise.
  - Reset mid-operation aborts the request: no later mem_wr_en, no done.
- IDLE:
  - req_ready=1. Accept when req_valid & req_ready at a clock edge; latch addr, data and size.
  - Misaligned requests go to ERR: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Aligned word goes directly to WRITE with merged word = req_data (no read).
  - Byte and aligned half go to READ.
- READ: mem_rd_en=1, mem_addr=word address; next state MERGE.
- MERGE:
  - Capture mem_rdata and replace the lane(s), little-endian.
  - Byte lane k=addr[1:0] gets data[7:0] into bits [8k+7:8k].
  - Half uses addr[1]: 0 puts data[15:0] into [15:0]; 1 puts it into [31:16].
  - Other bits keep the old value. Next state WRITE.
- WRITE: mem_wr_en=1, mem_addr=word address, mem_wdata=merged word; next state IDLE.
- ERR: no memory strobes; next state IDLE.
- Completion:
  - done (and misaligned from ERR) is registered on the edge leaving WRITE or ERR, so it is high during the first IDLE cycle.
  - A new request may be accepted in that same cycle.
- Latency, counting the accept edge as cycle 0 (all strobes exactly one cycle):
  - Byte/half: READ at cycle 1, MERGE at 2, WRITE at 3, done at 4.
  - Word: WRITE at 1, done at 2.
  - Error: ERR at 1, done+misaligned at 2.
- req_valid outside IDLE is ignored.
- req_* inputs need not be held after acceptance.
- mem_addr and mem_wdata hold their last values when strobes are low.

Optional Feature:
- Macro: STORE_OVF_CHECK_EN.
- Enabled: ovf=1 with done when req_data is not the sign-extension of the stored field.
  - Byte: data[31:8] != {24{data[7]}}.
  - Half: data[31:16] != {16{data[15]}}.
  - Word and misaligned: ovf=0.
- ovf is informational only; the write still happens.
- Disabled: the ovf port is present and tied to 0.

Decomposition:
- Package store_pkg: size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10; state encoding constants.
- One combinational sub-module, store_lane_merge, with inputs old word, new data, size and addr[1:0], and output the merged word. It is used in MERGE and is unit-testable in isolation.

Test Plan:
- Byte: memory[0x100]=0xAABBCCDD; addr 0x102, size 00, data 0x12345678.
  -> mem_rd_en at cycle 1 with mem_addr 0x100; mem_wr_en at cycle 3 with wdata 0xAA78CCDD; done at cycle 4; misaligned=0.
- Half: same memory; addr 0x102, size 01, data 0xFFFF8001.
  -> wdata 0x8001CCDD; ovf=0 with the macro enabled.
- Word: addr 0x104, data 0xDEADBEEF.
  -> no mem_rd_en; mem_wr_en at cycle 1 with addr 0x104 and wdata 0xDEADBEEF; done at cycle 2.
- Misaligned: half at 0x101, word at 0x106, size 11 at 0x100.
  -> each gives no rd/wr strobes and done=misaligned=1 at cycle 2. Back-to-back requests are accepted in the done cycle.
- Overflow: byte, addr 0x100, data 0x00000080.
  -> with STORE_OVF_CHECK_EN, ovf=1 and the low lane is still written as 0x80. Without the macro, ovf=0.
- Reset: rst_n driven low during MERGE of a byte store.
  -> no mem_wr_en, all outputs 0, req_ready=0 while in reset. After release, a word store completes normally.
